mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
Shares one combinational signed 16x16 multiplier (radix-4 Booth, Wallace tree) between NREQ requesters. Round-robin arbitration over valid/ready request channels feeds the multiplier from an operand register. Products return on a single response channel, tagged with the requester index. The two pipeline registers bracket the multiplier's combinational path, so the multiplier needs no clock of its own.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, requester-index width, equal to clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high per cycle
req_a  input  NREQ*16  operand A per requester, two's complement; requester i uses bits [16i+15:16i]
req_b  input  NREQ*16  operand B per requester, two's complement, same packing as req_a
mul_a  output  16  operand A to the shared multiplier, driven from the stage-1 register
mul_b  output  16  operand B to the shared multiplier, driven from the stage-1 register
mul_p  input  32  product from the shared multiplier (combinational function of mul_a, mul_b)
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of the requester that owns rsp_product
rsp_product  output  32  signed product
busy  output  1  s1_valid OR s2_valid

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, s2_valid=0, rr_ptr=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_product=0, busy=0. req_ready=0 while rst_n=0.
- Arbitration is combinational round-robin. Search starts at rr_ptr and wraps modulo NREQ. The first i with req_valid[i]=1 is the grantee.
- Handshake enables:
  - s2_en = !s2_valid | rsp_ready
  - s1_adv = s1_valid & s2_en
  - s1_en = !s1_valid | s1_adv
  - req_ready[i] = (i == grantee) & any(req_valid) & s1_en
- Transfer occurs on req_valid[i] & req_ready[i].
- On a transfer, at the clock edge:
  - s1 captures req_a slice, req_b slice and the index; s1_valid<=1.
  - rr_ptr <= (grantee+1) mod NREQ.
- When s1_en=1 and no transfer occurs: s1_valid<=0. Registers hold; rr_ptr holds.
- When s1_adv=1: s2 captures mul_p and the s1 index; s2_valid<=1.
- When s2_en=1 and s1_valid=0: s2_valid<=0.
- rsp_valid=s2_valid, rsp_product=s2 data, rsp_id=s2 index.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_product and rsp_id hold stable, and stalls propagate back to req_ready.
- Latency and throughput: a transfer in cycle T gives rsp_valid=1 in cycle T+2 when there is no backpressure. Full throughput is one product per cycle.
- Requester-side rules:
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - A requester holds its operands stable while req_valid=1 and it is not accepted.
- Arithmetic is the exact 32-bit two's-complement product. -32768 * -32768 = 0x40000000 with no overflow.
- Simultaneous events:
  - A transfer into s1, s1 moving to s2, and s2 being consumed may all happen in the same cycle.
  - Full pipeline with rsp_ready=0: all req_ready=0.
- Reset mid-operation: in-flight products are discarded with no response emitted, and rr_ptr returns to 0.
- Fairness: a continuously asserted requester is granted within NREQ accepted transfers.

Decomposition:
- Shared package mul_pkg holds:
  - constants OP_W=16, PROD_W=32;
  - typedef mul_req_t {a[15:0], b[15:0]};
  - typedef mul_rsp_t {id, product[31:0]}.
- One sub-module, rr_arbiter (NREQ):
  - inputs: req vector, rr_ptr;
  - outputs: one-hot grant and the grantee index.
- The multiplier is instantiated beside this block, not inside it, so it can be swapped or duplicated.

Test Plan:
- Single request, NREQ=4, req 2: a=0xFFFD (-3), b=0x0007, rsp_ready=1 -> rsp_valid two cycles after accept, rsp_id=2, rsp_product=0xFFFFFFEB.
- Corner operands: 0x8000*0x8000 -> 0x40000000; 0x7FFF*0x8000 -> 0xC0008000; 0x7FFF*0x7FFF -> 0x3FFF0001; 0*0xFFFF -> 0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1,...; one response per cycle; rsp_id sequence matches; req_ready is one-hot every cycle.
- Backpressure: stream 3 requests, then drop rsp_ready for 5 cycles -> rsp_product/rsp_id frozen; after 2 buffered entries all req_ready=0; no loss or duplication after rsp_ready returns.
- Round-robin pointer wrap: only req 3 active, then req 0 and req 3 active together -> req 0 granted first (rr_ptr wrapped to 0).
- Reset mid-flight: assert rst_n=0 with s1 and s2 both full -> rsp_valid=0 and busy=0 immediately; after release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
//   OP_W      operand width of the shared multiplier
//   PROD_W    product width
//   MAX_ID_W  widest requester index supported (NREQ up to 8)
//   mul_req_t operand pair held in the operand register
//   mul_rsp_t tagged product held in the response register
package mul_pkg;

    localparam int unsigned OP_W     = 16;
    localparam int unsigned PROD_W   = 32;
    localparam int unsigned MAX_ID_W = 3;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } mul_req_t;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [PROD_W-1:0]   product;
    } mul_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       request vector, one bit per requester
//   rr_ptr    index the search starts from (wraps modulo NREQ)
//   grant     one-hot grant, all zero when no request is pending
//   grant_idx index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    always_comb begin
        int unsigned idx;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Shares one external combinational signed 16x16 multiplier between NREQ
// requesters. A round-robin arbiter selects a requester into the operand
// register (stage 1), which drives mul_a/mul_b; the product mul_p is caught
// in the response register (stage 2), which drives the response channel.
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     per-requester request handshake
//   req_a, req_b            packed operands, requester i at [16i+15:16i]
//   mul_a, mul_b, mul_p     connection to the shared multiplier
//   rsp_valid/rsp_ready     response handshake
//   rsp_id, rsp_product     owning requester index and signed product
//   busy                    either pipeline stage holds data
module mul_share_arb
    import mul_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic [OP_W-1:0]      mul_a,
    output logic [OP_W-1:0]      mul_b,
    input  logic [PROD_W-1:0]    mul_p,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [PROD_W-1:0]    rsp_product,
    output logic                 busy
);

    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] grant_idx;

    logic            s1_valid_q;
    mul_req_t        s1_req_q;
    logic [ID_W-1:0] s1_id_q;
    logic            s2_valid_q;
    mul_rsp_t        s2_rsp_q;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    logic     s2_en, s1_adv, s1_en, any_req, xfer;
    mul_req_t sel_req;
    logic     unused_id_bits;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Stage 2 frees up when empty or being drained; stage 1 when empty or moving on.
    assign s2_en   = !s2_valid_q || rsp_ready;
    assign s1_adv  = s1_valid_q && s2_en;
    assign s1_en   = !s1_valid_q || s1_adv;
    assign any_req = |req_valid;

    // rst_n gates ready so nothing looks accepted while reset is held.
    assign req_ready = grant & {NREQ{any_req && s1_en && rst_n}};
    assign xfer      = |(req_valid & req_ready);

    always_comb begin
        sel_req = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_req.a = req_a[OP_W*i +: OP_W];
                sel_req.b = req_b[OP_W*i +: OP_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d = grant_idx + 1'b1;
        if (grant_idx == ID_W'(NREQ - 1)) begin
            rr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_req_q   <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_rsp_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            if (xfer) begin
                s1_valid_q <= 1'b1;
                s1_req_q   <= sel_req;
                s1_id_q    <= grant_idx;
                rr_ptr_q   <= rr_ptr_d;
            end else if (s1_en) begin
                s1_valid_q <= 1'b0;
            end

            if (s1_adv) begin
                s2_valid_q       <= 1'b1;
                s2_rsp_q.id      <= MAX_ID_W'(s1_id_q);
                s2_rsp_q.product <= mul_p;
            end else if (s2_en) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign mul_a       = s1_req_q.a;
    assign mul_b       = s1_req_q.b;
    assign rsp_valid   = s2_valid_q;
    assign rsp_id      = s2_rsp_q.id[ID_W-1:0];
    assign rsp_product = s2_rsp_q.product;
    assign busy        = s1_valid_q || s2_valid_q;

    // Upper id bits are zero for small NREQ.
    assign unused_id_bits = ^s2_rsp_q.id;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: randomized requesters plus directed scenarios,
// checked against a transaction-level model (capacity-two in-order buffer,
// round-robin pick from a pointer, exact signed product).
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_a, req_b;
    logic [15:0]       mul_a, mul_b;
    logic [31:0]       mul_p;
    logic              rsp_valid, rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_product;
    logic              busy;

    always #5 clk = ~clk;

    // Stand-in for the shared multiplier that lives beside the block.
    assign mul_p = 32'($signed(mul_a) * $signed(mul_b));

    mul_share_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_p       (mul_p),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy)
    );

    typedef struct {
        int          id;
        logic [31:0] prod;
        int          age;
    } item_t;

    item_t       q_m[$];
    int          ptr_m;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          pend_v[NREQ];
    logic [15:0] pend_a[NREQ];
    logic [15:0] pend_b[NREQ];
    int          refill_pct = 0;
    int          rsp_pct = 100;
    int          rsp_count = 0;
    logic [31:0] last_prod;
    logic [ID_W-1:0] last_id;
    logic [NREQ-1:0] last_ready;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return 32'(sa * sb);
    endfunction

    function automatic logic [15:0] rand_op();
        case ($urandom_range(7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = pend_v[i];
            req_a[16*i +: 16]  = pend_a[i];
            req_b[16*i +: 16]  = pend_b[i];
        end
        rsp_ready = (int'($urandom_range(99)) < rsp_pct);
    endtask

    // One clock cycle: check outputs at the falling edge, advance model at the rising edge.
    task automatic step();
        int              g;
        bit              can, exp_rv, fire;
        logic [NREQ-1:0] exp_ready;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (g < 0 && pend_v[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
        end
        can       = (g >= 0) && !(q_m.size() == 2 && !rsp_ready);
        exp_ready = '0;
        if (can) exp_ready[g] = 1'b1;
        exp_rv = (q_m.size() > 0) && (q_m[0].age >= 1);
        last_ready = req_ready;
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check_eq("busy", 64'(busy), 64'(q_m.size() > 0));
        if (exp_rv) begin
            check_eq("rsp_id", 64'(rsp_id), 64'(q_m[0].id));
            check_eq("rsp_product", 64'(rsp_product), 64'(q_m[0].prod));
        end
        fire = exp_rv && rsp_ready;
        if (fire) begin
            last_prod = rsp_product;
            last_id   = rsp_id;
            rsp_count++;
        end
        @(posedge clk);
        foreach (q_m[j]) q_m[j].age++;
        if (fire) void'(q_m.pop_front());
        if (can) begin
            q_m.push_back('{id: g, prod: ref_mul(pend_a[g], pend_b[g]), age: 0});
            ptr_m     = (g + 1) % NREQ;
            pend_v[g] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pend_v[i] && int'($urandom_range(99)) < refill_pct) begin
                pend_v[i] = 1'b1;
                pend_a[i] = rand_op();
                pend_b[i] = rand_op();
            end
        end
        #1 drive();
    endtask

    task automatic run_until_rsp(output int n);
        int r0;
        r0 = rsp_count;
        n  = 0;
        while (rsp_count == r0 && n < 20) begin
            step();
            n++;
        end
        check_eq("rsp_timeout", 64'(n < 20), 64'(1));
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
    endtask

    logic [15:0] c_a[4]   = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000};
    logic [15:0] c_b[4]   = '{16'h8000, 16'h8000, 16'h7FFF, 16'hFFFF};
    logic [31:0] c_exp[4] = '{32'h4000_0000, 32'hC000_8000, 32'h3FFF_0001, 32'h0000_0000};

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        ptr_m = 0;
        drive();
        req_valid = '1;

        // Reset values, with requests pending to show ready stays low.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_mul_a", 64'(mul_a), 64'(0));
        check_eq("rst_mul_b", 64'(mul_b), 64'(0));
        check_eq("rst_rsp_id", 64'(rsp_id), 64'(0));
        check_eq("rst_rsp_product", 64'(rsp_product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive();
        @(posedge clk);
        #1;

        // Single request from requester 2: -3 * 7, response two cycles after accept.
        set_req(2, 16'hFFFD, 16'h0007);
        drive();
        run_until_rsp(n);
        check_eq("single_latency", 64'(n), 64'(3));
        check_eq("single_id", 64'(last_id), 64'(2));
        check_eq("single_product", 64'(last_prod), 64'hFFFF_FFEB);

        // Corner operands.
        for (int c = 0; c < 4; c++) begin
            set_req(0, c_a[c], c_b[c]);
            drive();
            run_until_rsp(n);
            check_eq("corner_product", 64'(last_prod), 64'(c_exp[c]));
        end

        // All requesters continuously valid.
        refill_pct = 100;
        for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op());
        drive();
        repeat (16) step();
        refill_pct = 0;
        repeat (8) step();

        // Backpressure: three requests, then five stalled cycles.
        set_req(0, rand_op(), rand_op());
        set_req(1, rand_op(), rand_op());
        set_req(2, rand_op(), rand_op());
        drive();
        repeat (2) step();
        rsp_pct   = 0;
        rsp_ready = 1'b0;
        repeat (5) step();
        rsp_pct   = 100;
        rsp_ready = 1'b1;
        repeat (8) step();

        // Pointer wrap: requester 3 alone, then 0 and 3 together.
        set_req(3, rand_op(), rand_op());
        drive();
        step();
        check_eq("wrap_first", 64'(last_ready), 64'(4'b1000));
        set_req(0, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        drive();
        step();
        check_eq("wrap_second", 64'(last_ready), 64'(4'b0001));
        repeat (6) step();

        // Randomized traffic with random backpressure.
        refill_pct = 30;
        rsp_pct    = 70;
        repeat (400) step();
        refill_pct = 0;
        rsp_pct    = 100;
        repeat (12) step();

        // Reset with both stages full.
        rsp_pct   = 0;
        rsp_ready = 1'b0;
        set_req(0, rand_op(), rand_op());
        set_req(1, rand_op(), rand_op());
        set_req(2, rand_op(), rand_op());
        drive();
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_req_ready", 64'(req_ready), 64'(0));
        q_m.delete();
        ptr_m = 0;
        for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
        rsp_pct = 100;
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(1, rand_op(), rand_op());
        set_req(3, rand_op(), rand_op());
        drive();
        step();
        check_eq("post_rst_grant", 64'(last_ready), 64'(4'b0010));
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
